// File: rtl/core_imm_enc_if.sv
// Field-bundle in / instruction-word out handshake bundle for the immediate encoder.
// The master modport is the producer/consumer side; the slave modport is the encoder.
`timescale 1ns/1ps
interface core_imm_enc_if #(
  parameter int OPERAND_WIDTH = 64,
  parameter int INSTR_WIDTH   = 32,
  parameter int CNT_WIDTH     = 16
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [2:0]               fmt_i;
  logic [6:0]               opcode_i;
  logic [4:0]               rd_i;
  logic [4:0]               rs1_i;
  logic [4:0]               rs2_i;
  logic [2:0]               funct3_i;
  logic [6:0]               funct7_i;
  logic [OPERAND_WIDTH-1:0] imm_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [INSTR_WIDTH-1:0]   instr_o;
  logic                     err_o;
  logic [CNT_WIDTH-1:0]     enc_cnt_o;

  modport master (
    output in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, enc_cnt_o
  );

  modport slave (
    input  in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
           out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, enc_cnt_o
  );
endinterface

// File: rtl/core_imm_enc.sv
// Packs decoded RV64IM fields into a 32-bit instruction word behind a 2-entry output FIFO.
// Optional immediate range checking is built when IMM_ENC_RANGE_CHK_EN is defined.
`timescale 1ns/1ps
module core_imm_enc #(
  parameter int OPERAND_WIDTH = 64,
  parameter int INSTR_WIDTH   = 32,
  parameter int CNT_WIDTH     = 16
) (
  input logic           clk,
  input logic           rst_n,
  core_imm_enc_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  function automatic logic [INSTR_WIDTH-1:0] encodeWord(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    case (fmt)
      FMT_R:   encodeWord = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   encodeWord = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   encodeWord = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   encodeWord = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   encodeWord = {imm[31:12], rd, op};
      FMT_J:   encodeWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: encodeWord = '0;
    endcase
  endfunction

`ifdef IMM_ENC_RANGE_CHK_EN
  // True when imm is representable as a bits-wide two's-complement value.
  function automatic logic fitsSigned(input logic [OPERAND_WIDTH-1:0] imm, input int bits);
    logic signed [OPERAND_WIDTH-1:0] sh;
    sh = $signed(imm) >>> (bits - 1);
    fitsSigned = (sh == '0) || (sh == '1);
  endfunction

  function automatic logic rangeErr(input logic [2:0] fmt, input logic [OPERAND_WIDTH-1:0] imm);
    case (fmt)
      FMT_R:        rangeErr = 1'b0;
      FMT_I, FMT_S: rangeErr = !fitsSigned(imm, 12);
      FMT_B:        rangeErr = !fitsSigned(imm, 13) || imm[0];
      FMT_U:        rangeErr = (imm[11:0] != 12'd0) || !fitsSigned(imm, 32);
      FMT_J:        rangeErr = !fitsSigned(imm, 21) || imm[0];
      default:      rangeErr = 1'b1;
    endcase
  endfunction
`endif

  logic [1:0]             count;
  logic                   wrPtr;
  logic                   rdPtr;
  logic [CNT_WIDTH-1:0]   encCnt;
  logic                   outValid;
  logic                   push;
  logic                   pop;
  logic                   inReady;
  logic [INSTR_WIDTH-1:0] encWord_p0;
  logic [INSTR_WIDTH-1:0] instrFifo_p1 [2];

  assign outValid = (count != 2'd0);
  assign pop      = outValid && bus.out_ready_i;
  assign inReady  = (count != 2'd2) || pop;
  assign push     = bus.in_valid_i && inReady;

  // Stage 0: combinational encode of the offered bundle
  assign encWord_p0 = encodeWord(bus.fmt_i, bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                                 bus.funct3_i, bus.funct7_i, bus.imm_i[31:0]);

  // Stage 1: FIFO storage; payload carries no reset, only pointers/occupancy do
  always_ff @(posedge clk) begin
    if (push) instrFifo_p1[wrPtr] <= encWord_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      encCnt <= '0;
    end else begin
      if (push) begin
        wrPtr  <= ~wrPtr;
        encCnt <= encCnt + 1'b1;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMM_ENC_RANGE_CHK_EN
  logic errFifo_p1 [2];

  always_ff @(posedge clk) begin
    if (push) errFifo_p1[wrPtr] <= rangeErr(bus.fmt_i, bus.imm_i);
  end

  assign bus.err_o = outValid ? errFifo_p1[rdPtr] : 1'b0;
`else
  logic unusedImmHi;
  assign unusedImmHi = ^bus.imm_i[OPERAND_WIDTH-1:32];
  assign bus.err_o   = 1'b0;
`endif

  // Empty FIFO presents an all-zero word so the idle/reset output is deterministic.
  assign bus.instr_o     = outValid ? instrFifo_p1[rdPtr] : '0;
  assign bus.out_valid_o = outValid;
  assign bus.in_ready_o  = inReady;
  assign bus.enc_cnt_o   = encCnt;

endmodule

// File: tb/tb_core_imm_enc.sv
// Directed bench for core_imm_enc: encodings, range errors, backpressure, async reset, counter wrap.
`timescale 1ns/1ps
module tb_core_imm_enc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_imm_enc_if #(.OPERAND_WIDTH(64), .INSTR_WIDTH(32), .CNT_WIDTH(16)) bus ();

  core_imm_enc #(.OPERAND_WIDTH(64), .INSTR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef IMM_ENC_RANGE_CHK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [31:0] exp;
    logic        errChk;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [15:0] expCnt;

  task automatic driveVec(input vec_t v);
    bus.fmt_i      = v.fmt;
    bus.opcode_i   = v.op;
    bus.rd_i       = v.rd;
    bus.rs1_i      = v.rs1;
    bus.rs2_i      = v.rs2;
    bus.funct3_i   = v.f3;
    bus.funct7_i   = v.f7;
    bus.imm_i      = v.imm;
    bus.in_valid_i = 1'b1;
  endtask

  task automatic doReset();
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expCnt = 16'd0;
  endtask

  task automatic test_reset();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.fmt_i = 3'd0; bus.opcode_i = 7'd0; bus.rd_i = 5'd0; bus.rs1_i = 5'd0;
    bus.rs2_i = 5'd0; bus.funct3_i = 3'd0; bus.funct7_i = 7'd0; bus.imm_i = 64'd0;
    doReset();
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", bus.instr_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
    checks++; if (bus.enc_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", bus.enc_cnt_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
  endtask

  task automatic test_encode();
    vec_t v [16];
    logic expErr;
    v[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, 64'd5,                 32'h00500093, 1'b0};
    v[1]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFFFFFFFFFFFFFC, 32'hFE000EE3, 1'b0};
    v[2]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000012345000, 32'h123452B7, 1'b0};
    v[3]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000000000800, 32'h001000EF, 1'b0};
    v[4]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'hDEADBEEF00000001, 32'h402081B3, 1'b0};
    v[5]  = '{3'd2, 7'h23, 5'd7, 5'd1, 5'd2, 3'd2, 7'h00, 64'd8,                 32'h0020A423, 1'b0};
    v[6]  = '{3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFFFFFFFFFFFFFF, 32'hFE000FA3, 1'b0};
    v[7]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd2048,              32'h80000093, 1'b1};
    v[8]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5,                 32'h00000263, 1'b1};
    v[9]  = '{3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000012345001, 32'h12345037, 1'b1};
    v[10] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000000100000, 32'h8000006F, 1'b1};
    v[11] = '{3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h01, 64'd1,                 32'h00000000, 1'b1};
    v[12] = '{3'd6, 7'h33, 5'd4, 5'd5, 5'd6, 3'd2, 7'h20, 64'd0,                 32'h00000000, 1'b1};
    v[13] = '{3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000080000000, 32'h80000037, 1'b1};
    v[14] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFFFFFFFFFFFFFE, 32'hFFFFF0EF, 1'b0};
    v[15] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFFFFFFFFFFF800, 32'h80000093, 1'b0};
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      driveVec(v[i]);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      expCnt = expCnt + 16'd1;
      expErr = v[i].errChk & ERR_ON;
      #1;
      checks++; if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL enc%0d_valid got=%b exp=1", i, bus.out_valid_o); end
      checks++; if (bus.instr_o !== v[i].exp) begin failures++; $display("FAIL enc%0d_instr got=%h exp=%h", i, bus.instr_o, v[i].exp); end
      checks++; if (bus.err_o !== expErr) begin failures++; $display("FAIL enc%0d_err got=%b exp=%b", i, bus.err_o, expErr); end
      checks++; if (bus.enc_cnt_o !== expCnt) begin failures++; $display("FAIL enc%0d_cnt got=%h exp=%h", i, bus.enc_cnt_o, expCnt); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL enc_drain_valid got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_back_to_back();
    vec_t a, b, c;
    a = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5,                 32'h00500093, 1'b0};
    b = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000012345000, 32'h123452B7, 1'b0};
    c = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000000000000800, 32'h001000EF, 1'b0};
    doReset();
    bus.out_ready_i = 1'b0;
    @(negedge clk); driveVec(a);
    @(negedge clk); driveVec(b);
    @(negedge clk); driveVec(c);
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready_o); end
    checks++; if (bus.instr_o !== a.exp) begin failures++; $display("FAIL bp_head got=%h exp=%h", bus.instr_o, a.exp); end
    checks++; if (bus.enc_cnt_o !== 16'd2) begin failures++; $display("FAIL bp_cnt2 got=%h exp=0002", bus.enc_cnt_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b exp=0", bus.in_ready_o); end
    checks++; if (bus.instr_o !== a.exp) begin failures++; $display("FAIL bp_hold_head got=%h exp=%h", bus.instr_o, a.exp); end
    checks++; if (bus.enc_cnt_o !== 16'd2) begin failures++; $display("FAIL bp_hold_cnt got=%h exp=0002", bus.enc_cnt_o); end
    bus.out_ready_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_pop_ready got=%b exp=1", bus.in_ready_o); end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    checks++; if (bus.instr_o !== b.exp) begin failures++; $display("FAIL bp_second got=%h exp=%h", bus.instr_o, b.exp); end
    checks++; if (bus.enc_cnt_o !== 16'd3) begin failures++; $display("FAIL bp_cnt3 got=%h exp=0003", bus.enc_cnt_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_third_valid got=%b exp=1", bus.out_valid_o); end
    checks++; if (bus.instr_o !== c.exp) begin failures++; $display("FAIL bp_third got=%h exp=%h", bus.instr_o, c.exp); end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid_o); end
    expCnt = 16'd3;
  endtask

  task automatic test_async_reset();
    vec_t d, e;
    d = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5,  32'h00500093, 1'b0};
    e = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 64'd8,  32'h0020A423, 1'b0};
    bus.out_ready_i = 1'b0;
    @(negedge clk); driveVec(d);
    @(negedge clk); driveVec(e);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    checks++; if (bus.enc_cnt_o !== 16'd5) begin failures++; $display("FAIL ar_pre_cnt got=%h exp=0005", bus.enc_cnt_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", bus.out_valid_o); end
    checks++; if (bus.enc_cnt_o !== 16'd0) begin failures++; $display("FAIL ar_cnt got=%h exp=0000", bus.enc_cnt_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", bus.in_ready_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL ar_instr got=%h exp=00000000", bus.instr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk); driveVec(e);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    checks++; if (bus.instr_o !== e.exp) begin failures++; $display("FAIL ar_next_instr got=%h exp=%h", bus.instr_o, e.exp); end
    checks++; if (bus.enc_cnt_o !== 16'd1) begin failures++; $display("FAIL ar_next_cnt got=%h exp=0001", bus.enc_cnt_o); end
    expCnt = 16'd1;
  endtask

  task automatic test_cnt_wrap();
    vec_t w;
    w = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5, 32'h00500093, 1'b0};
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    driveVec(w);
    repeat (65534) @(negedge clk);
    #1;
    checks++; if (bus.enc_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", bus.enc_cnt_o); end
    checks++; if (bus.instr_o !== w.exp) begin failures++; $display("FAIL wrap_stream_instr got=%h exp=%h", bus.instr_o, w.exp); end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    checks++; if (bus.enc_cnt_o !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", bus.enc_cnt_o); end
    checks++; if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", bus.out_valid_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_async_reset();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
